utm_step_controller: RTL
========================

// Module: utm_step_controller
// PURPOSE
//  Sequences one Turing-machine step per transaction: sample tape symbol, look up rule {state,sym} in an
//  external sync transition ROM, then issue write-symbol + move to the tape port. Sits between the tape
//  storage and the rule ROM. Owns machine state, halt detection and step counting.
// PARAMETERS
//  STATE_W   4   machine-state width; state 0 is the start state
//  SYM_W     3   tape-symbol width
//  CNT_W     32  step-counter / step-limit width
// PORTS
//  clock        in   1                    rising-edge clock
//  reset        in   1                    asynchronous, active-high; clears all regs
//  start        in   1                    1-cycle pulse; begins run from IDLE or DONE
//  step_limit   in   CNT_W                0 = unlimited; else abort after this many steps
//  tape_sym     in   SYM_W                symbol under head; valid when tape_sym_valid
//  tape_sym_valid in 1                    tape has a stable symbol to read
//  tape_op_valid out 1                    write+move command valid
//  tape_op_ready in  1                    tape accepts command (transfer = valid & ready)
//  tape_new_sym out  SYM_W                symbol to write
//  tape_dir     out  1                    1 = right (+1), 0 = left (-1)
//  tape_at_edge in   1                    head at position 0; treated as fatal
//  rule_addr    out  STATE_W+SYM_W        {state, sym} to ROM
//  rule_rd      out  1                    ROM read strobe; data valid next cycle
//  rule_data    in   STATE_W+SYM_W+2      {next_state, new_sym, dir, halt}, MSB first
//  state        out  STATE_W              current machine state
//  step_count   out  CNT_W                completed steps (saturating)
//  busy         out  1                    high in FETCH/LOOKUP/ISSUE
//  halted       out  1                    sticky: rule halt bit seen
//  error        out  1                    sticky: edge hit or step limit reached
// BEHAVIOUR
//  Reset values: all outputs 0; fsm=IDLE, state=0, step_count=0.
//  FSM: IDLE -start-> FETCH; FETCH -tape_sym_valid-> LOOKUP (latch sym, rule_rd=1 this cycle);
//   LOOKUP (1 cycle, ROM data arrives) -> halt bit ? DONE(halted=1, no write) : ISSUE;
//   ISSUE: tape_op_valid=1, new_sym/dir held stable until ready; on transfer: state<=next_state,
//   step_count++, -> FETCH, or DONE(error=1) if step_limit!=0 && step_count+1==step_limit.
//  DONE -start-> FETCH; start clears halted/error/step_count, state<=0 (tape not rewound).
//  start while busy: ignored. Latency FETCH->transfer min 3 cycles (sym_valid, lookup, ready same cycle).
//  tape_at_edge sampled in FETCH: if 1 -> DONE, error=1, no lookup issued.
//  rule_addr = {state, latched_sym}; stays constant from FETCH exit through LOOKUP.
//  tape_op_valid must not drop before ready (no retraction); outputs registered, not comb from ready.
//  step_count saturates at all-ones; no wrap.
//  Async reset mid-ISSUE: command dropped immediately; tape side must tolerate valid falling.
//  Simultaneous halt bit and step limit: halt wins (halted=1, error=0).
// STRUCTURE
//  Shared package utm_pkg: fsm enum {IDLE,FETCH,LOOKUP,ISSUE,DONE}, rule-field slice localparams,
//  DIR_LEFT/DIR_RIGHT constants. Single module; no sub-module warranted.
// TESTING
//  BB2 table, tape all 0, limit 0, ready tied 1 -> halted=1 after 6 steps, state=halt src, error=0.
//  Same table, step_limit=3 -> DONE at step_count=3, error=1, halted=0, exactly 3 op transfers.
//  ready held low 5 cycles in ISSUE -> new_sym/dir/valid stable all 5 cycles, one transfer only.
//  tape_at_edge=1 on 2nd FETCH -> error=1, step_count=1, rule_rd never pulsed again.
//  reset asserted in ISSUE -> same-cycle (async) all outputs 0, fsm IDLE; start restarts from state 0.
//  start pulsed while busy -> ignored; start in DONE -> counters cleared, run resumes from state 0.

Source files
------------

// File: rtl/utm_pkg.sv
// Shared types and constants for the Turing-machine step controller.
// Rule word layout, MSB first: {next_state, new_sym, dir, halt}.
package utm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOOKUP,
    ISSUE,
    DONE
  } fsm_t;

  localparam int RULE_HALT_BIT = 0;
  localparam int RULE_DIR_BIT  = 1;
  localparam int RULE_SYM_LSB  = 2;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/utm_step_controller.sv
// Sequences one Turing-machine step per transaction: read tape symbol, look up
// {state,sym} in a synchronous rule ROM, then issue write+move to the tape.
module utm_step_controller
  import utm_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int SYM_W   = 3,
  parameter int CNT_W   = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [CNT_W-1:0]           step_limit,
  input  logic [SYM_W-1:0]           tape_sym,
  input  logic                       tape_sym_valid,
  output logic                       tape_op_valid,
  input  logic                       tape_op_ready,
  output logic [SYM_W-1:0]           tape_new_sym,
  output logic                       tape_dir,
  input  logic                       tape_at_edge,
  output logic [STATE_W+SYM_W-1:0]   rule_addr,
  output logic                       rule_rd,
  input  logic [STATE_W+SYM_W+1:0]   rule_data,
  output logic [STATE_W-1:0]         state,
  output logic [CNT_W-1:0]           step_count,
  output logic                       busy,
  output logic                       halted,
  output logic                       error
);

  fsm_t               fsm_q;
  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] next_state_q;
  logic [SYM_W-1:0]   sym_q;
  logic [SYM_W-1:0]   new_sym_q;
  logic               dir_q;
  logic               op_valid_q;
  logic [CNT_W-1:0]   count_q;
  logic               halted_q;
  logic               error_q;

  logic [CNT_W-1:0]   count_d;
  logic [CNT_W:0]     count_inc;
  logic               limit_hit;
  logic               fetch_go;
  logic [STATE_W-1:0] rule_next;
  logic [SYM_W-1:0]   rule_sym;
  logic               rule_dir;
  logic               rule_halt;

  assign rule_next = rule_data[STATE_W+SYM_W+1 -: STATE_W];
  assign rule_sym  = rule_data[RULE_SYM_LSB +: SYM_W];
  assign rule_dir  = rule_data[RULE_DIR_BIT];
  assign rule_halt = rule_data[RULE_HALT_BIT];

  // The ROM samples its address on the FETCH exit edge, so the read strobe and
  // address are presented during FETCH; the ROM word then lands in LOOKUP.
  assign fetch_go  = (fsm_q == FETCH) && tape_sym_valid && !tape_at_edge;
  assign rule_rd   = fetch_go;
  assign rule_addr = {state_q, (fsm_q == FETCH) ? tape_sym : sym_q};

  // Wider sum so the limit compare cannot alias when the counter is all-ones.
  assign count_inc = {1'b0, count_q} + {{CNT_W{1'b0}}, 1'b1};
  assign count_d   = (&count_q) ? count_q : count_inc[CNT_W-1:0];
  assign limit_hit = (step_limit != '0) && (count_inc == {1'b0, step_limit});

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm_q        <= IDLE;
      state_q      <= '0;
      next_state_q <= '0;
      sym_q        <= '0;
      new_sym_q    <= '0;
      dir_q        <= 1'b0;
      op_valid_q   <= 1'b0;
      count_q      <= '0;
      halted_q     <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE, DONE: begin
          if (start) begin
            fsm_q    <= FETCH;
            state_q  <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
          end
        end
        FETCH: begin
          if (tape_at_edge) begin
            error_q <= 1'b1;
            fsm_q   <= DONE;
          end else if (tape_sym_valid) begin
            sym_q <= tape_sym;
            fsm_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (rule_halt) begin
            halted_q <= 1'b1;
            fsm_q    <= DONE;
          end else begin
            next_state_q <= rule_next;
            new_sym_q    <= rule_sym;
            dir_q        <= rule_dir;
            op_valid_q   <= 1'b1;
            fsm_q        <= ISSUE;
          end
        end
        ISSUE: begin
          if (tape_op_ready) begin
            op_valid_q <= 1'b0;
            state_q    <= next_state_q;
            count_q    <= count_d;
            if (limit_hit) begin
              error_q <= 1'b1;
              fsm_q   <= DONE;
            end else begin
              fsm_q <= FETCH;
            end
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign tape_op_valid = op_valid_q;
  assign tape_new_sym  = new_sym_q;
  assign tape_dir      = dir_q;
  assign state         = state_q;
  assign step_count    = count_q;
  assign halted        = halted_q;
  assign error         = error_q;
  assign busy          = (fsm_q == FETCH) || (fsm_q == LOOKUP) || (fsm_q == ISSUE);

endmodule
